// File: rtl/up_pkg.sv
// Shared types and defaults for the up core boot loader.
package up_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int RST_CYC_DEF = 4;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RESET = 2'd3
    } ld_state_t;

endpackage

// File: rtl/up_loader_if.sv
// Byte-level bundle between the loader, the UART rx/tx, the memory write port and the core controls.
interface up_loader_if
    import up_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              rx_valid;
    byte_t             rx_data;
    logic              tx_ready;
    logic              tx_valid;
    byte_t             tx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    byte_t             mem_wdata;
    logic              core_halt;
    logic              core_rst;
    byte_t             csum;
    logic              wrapped;
    logic              echo_drop;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, mem_we, mem_addr, mem_wdata,
        output core_halt, core_rst, csum, wrapped, echo_drop
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, mem_we, mem_addr, mem_wdata,
        input  core_halt, core_rst, csum, wrapped, echo_drop
    );

endinterface

// File: rtl/up_sync.sv
// Multi-stage flop synchroniser for slow asynchronous pins (prog, interrupt lines).
module up_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) q_reg <= '0;
                    else     q_reg <= d;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (rst) q_reg <= '0;
                    else     q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/up_loader.sv
// Boot loader: streams UART bytes into up_memory while prog is held, then pulses core reset and
// releases the core. Each loaded byte is echoed back and summed for host-side verification.
module up_loader
    import up_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RST_CYC = RST_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog,
    up_loader_if.master bus
);

    localparam int CNT_W = $clog2(RST_CYC + 1);

    ld_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    byte_t             csum_reg, csum_next;
    byte_t             tx_data_reg, tx_data_next;
    byte_t             mem_wdata_reg, mem_wdata_next;
    logic              wrapped_reg, wrapped_next;
    logic              echo_drop_reg, echo_drop_next;
    logic              tx_valid_reg, tx_valid_next;
    logic              mem_we_reg, mem_we_next;
    logic              progs, progs_d_reg, prog_fall, accept;

    up_sync #(.WIDTH(1), .STAGES(2)) u_prog_sync (
        .clk (clk),
        .rst (rst),
        .d   (prog),
        .q   (progs)
    );

    assign prog_fall = progs_d_reg & ~progs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            addr_reg      <= '0;
            mem_addr_reg  <= '0;
            cnt_reg       <= CNT_W'(RST_CYC);
            csum_reg      <= '0;
            tx_data_reg   <= '0;
            mem_wdata_reg <= '0;
            wrapped_reg   <= 1'b0;
            echo_drop_reg <= 1'b0;
            tx_valid_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            progs_d_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            mem_addr_reg  <= mem_addr_next;
            cnt_reg       <= cnt_next;
            csum_reg      <= csum_next;
            tx_data_reg   <= tx_data_next;
            mem_wdata_reg <= mem_wdata_next;
            wrapped_reg   <= wrapped_next;
            echo_drop_reg <= echo_drop_next;
            tx_valid_reg  <= tx_valid_next;
            mem_we_reg    <= mem_we_next;
            progs_d_reg   <= progs;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        mem_addr_next  = mem_addr_reg;
        cnt_next       = cnt_reg;
        csum_next      = csum_reg;
        tx_data_next   = tx_data_reg;
        mem_wdata_next = mem_wdata_reg;
        wrapped_next   = wrapped_reg;
        echo_drop_next = echo_drop_reg;
        tx_valid_next  = tx_valid_reg;
        mem_we_next    = 1'b0;
        accept         = bus.rx_valid && (state_reg == LOAD || state_reg == DRAIN);

        // One counter serves both the post-rst pulse and the RESET state pulse.
        if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;

        case (state_reg)
            RUN: begin
                // Level test so a prog held through DRAIN/RESET starts a new session at once.
                if (progs) begin
                    state_next     = LOAD;
                    addr_next      = '0;
                    csum_next      = '0;
                    wrapped_next   = 1'b0;
                    echo_drop_next = 1'b0;
                end
            end
            LOAD:  if (prog_fall) state_next = DRAIN;
            DRAIN: begin
                state_next = RESET;
                cnt_next   = CNT_W'(RST_CYC);
            end
            RESET: if (cnt_reg == CNT_W'(1)) state_next = RUN;
            default: state_next = RUN;
        endcase

        if (accept) begin
            mem_we_next    = 1'b1;
            mem_addr_next  = addr_reg;
            mem_wdata_next = bus.rx_data;
            addr_next      = addr_reg + 1'b1;
            csum_next      = csum_reg + bus.rx_data;
            if (addr_reg == '1) wrapped_next = 1'b1;
        end

        if (tx_valid_reg && bus.tx_ready) tx_valid_next = 1'b0;
        if (accept) begin
            if (tx_valid_reg && !bus.tx_ready) echo_drop_next = 1'b1;
            tx_valid_next = 1'b1;
            tx_data_next  = bus.rx_data;
        end
    end

    assign bus.tx_valid  = tx_valid_reg;
    assign bus.tx_data   = tx_data_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.core_halt = (state_reg != RUN);
    assign bus.core_rst  = (cnt_reg != '0);
    assign bus.csum      = csum_reg;
    assign bus.wrapped   = wrapped_reg;
    assign bus.echo_drop = echo_drop_reg;

endmodule

// File: tb/tb_up_loader.sv
// Directed plus randomized bench for up_loader against a session-level model of the loader.
module tb_up_loader;
    import up_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int RST_CYC = 4;
    localparam int DEPTH   = 256;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic prog = 1'b0;

    up_loader_if #(.ADDR_W(ADDR_W)) bus ();

    up_loader #(.ADDR_W(ADDR_W), .RST_CYC(RST_CYC)) dut (
        .clk  (clk),
        .rst  (rst),
        .prog (prog),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model state: bytes loaded this session, running sum, echo holding flag, drop flag, memory image.
    int    n_cmp = 0;
    int    n_mis = 0;
    int    n_loaded = 0;
    int    sum = 0;
    bit    pending = 1'b0;
    bit    drop = 1'b0;
    byte_t exp_mem [DEPTH];
    byte_t shadow  [DEPTH];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) shadow[bus.mem_addr] = bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        bit r = bus.tx_ready;
        @(negedge clk);
        if (r) pending = 1'b0;
        check("idle_mem_we", 32'(bus.mem_we), 32'd0);
        check("tx_valid_track", 32'(bus.tx_valid), 32'(pending));
    endtask

    task automatic send(input byte_t b);
        int a = n_loaded % DEPTH;
        if (pending && !bus.tx_ready) drop = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = byte_t'($urandom);
        pending  = 1'b1;
        n_loaded++;
        sum      = (sum + int'(b)) % 256;
        exp_mem[a] = b;
        check("wr_we",      32'(bus.mem_we),    32'd1);
        check("wr_addr",    32'(bus.mem_addr),  32'(a));
        check("wr_data",    32'(bus.mem_wdata), 32'(b));
        check("echo_valid", 32'(bus.tx_valid),  32'd1);
        check("echo_data",  32'(bus.tx_data),   32'(b));
        check("csum",       32'(bus.csum),      32'(sum));
        check("wrapped",    32'(bus.wrapped),   32'(n_loaded >= DEPTH));
        check("echo_drop",  32'(bus.echo_drop), 32'(drop));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        prog = 1'b0;
        pending = 1'b0;
        drop = 1'b0;
        sum = 0;
        n_loaded = 0;
        tick();
        rst = 1'b0;
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_tx_data",   32'(bus.tx_data),   32'd0);
        check("rst_csum",      32'(bus.csum),      32'd0);
        check("rst_wrapped",   32'(bus.wrapped),   32'd0);
        check("rst_echo_drop", 32'(bus.echo_drop), 32'd0);
        for (int i = 0; i < RST_CYC; i++) begin
            check("rst_core_rst",  32'(bus.core_rst),  32'd1);
            check("rst_core_halt", 32'(bus.core_halt), 32'd0);
            tick();
        end
        check("rst_core_rst_end", 32'(bus.core_rst), 32'd0);
    endtask

    task automatic enter_load();
        int k = 0;
        prog = 1'b1;
        while (bus.core_halt !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("load_entry_halt", 32'(bus.core_halt), 32'd1);
        n_loaded = 0;
        sum = 0;
        drop = 1'b0;
        check("load_csum_clr",      32'(bus.csum),      32'd0);
        check("load_wrapped_clr",   32'(bus.wrapped),   32'd0);
        check("load_echo_drop_clr", 32'(bus.echo_drop), 32'd0);
    endtask

    task automatic release_prog();
        int k = 0;
        int w = 0;
        prog = 1'b0;
        while (bus.core_rst !== 1'b1 && k < 20) begin
            check("drain_halt", 32'(bus.core_halt), 32'd1);
            tick();
            k++;
        end
        check("release_core_rst", 32'(bus.core_rst), 32'd1);
        while (bus.core_rst === 1'b1 && w < 20) begin
            check("reset_halt", 32'(bus.core_halt), 32'd1);
            tick();
            w++;
        end
        check("reset_pulse_len", 32'(w), 32'(RST_CYC));
        check("run_halt",        32'(bus.core_halt), 32'd0);
        check("run_csum_hold",   32'(bus.csum), 32'(sum));
    endtask

    initial begin
        byte_t basic [4];
        int    cnt;
        basic = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = 8'h00;
            shadow[i]  = 8'h00;
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;

        do_reset();

        // Four-byte program
        enter_load();
        for (int i = 0; i < 4; i++) begin
            send(basic[i]);
            repeat ($urandom_range(0, 2)) tick();
        end
        check("basic_csum", 32'(bus.csum), 32'h0000_00AA);
        release_prog();

        // 257 bytes: address wraps and byte 257 lands on address 0
        enter_load();
        for (int i = 0; i < DEPTH; i++) begin
            send(byte_t'(i));
            if ($urandom_range(0, 7) == 0) tick();
        end
        send(8'h00);
        check("wrap_last_addr", 32'(bus.mem_addr), 32'd0);
        check("wrap_csum",      32'(bus.csum),     32'h0000_0080);
        check("wrap_flag",      32'(bus.wrapped),  32'd1);
        release_prog();

        // Byte arriving in the same cycle the synchronised prog falls
        enter_load();
        send(8'h3C);
        tick();
        prog = 1'b0;
        tick();
        tick();
        send(8'hC3);
        release_prog();

        // Echo overrun under tx backpressure
        bus.tx_ready = 1'b0;
        enter_load();
        send(8'h5A);
        tick();
        send(8'hA5);
        check("echo_last_data", 32'(bus.tx_data),   32'h0000_00A5);
        check("echo_drop_set",  32'(bus.echo_drop), 32'd1);
        bus.tx_ready = 1'b1;
        tick();
        check("echo_cleared",   32'(bus.tx_valid),  32'd0);
        release_prog();

        // Randomized session with random backpressure and gaps
        enter_load();
        cnt = int'($urandom_range(8, 24));
        for (int i = 0; i < cnt; i++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            send(byte_t'($urandom));
            repeat ($urandom_range(0, 2)) begin
                bus.tx_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        bus.tx_ready = 1'b1;
        tick();
        release_prog();

        // Abort after 3 of 5 bytes, then rx traffic while running is ignored
        enter_load();
        for (int i = 0; i < 3; i++) send(byte_t'($urandom));
        do_reset();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hEE;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        check("run_rx_csum", 32'(bus.csum), 32'd0);

        for (int i = 0; i < DEPTH; i++) check("mem_image", 32'(shadow[i]), 32'(exp_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
